// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: NUM_M masters share one slave, one transaction in flight.
// Grant/accept in IDLE, request to slave one cycle later, response to the master one cycle after the slave answers or times out.
module bus_rr_arbiter #(
   parameter int WIDTH   = 2,
   parameter int NUM_M   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [NUM_M-1:0]       m_req_valid,
   input  logic [NUM_M*WIDTH-1:0] m_req_data,
   output logic [NUM_M-1:0]       m_req_ready,
   output logic [NUM_M-1:0]       m_rsp_valid,
   output logic [WIDTH-1:0]       m_rsp_data,
   output logic                   m_rsp_err,
   output logic                   s_req_valid,
   output logic [WIDTH-1:0]       s_req_data,
   input  logic                   s_req_ready,
   input  logic                   s_rsp_valid,
   input  logic [WIDTH-1:0]       s_rsp_data
);

   localparam int PW = $clog2(NUM_M);
   localparam int IW = PW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     grant_q;
   logic [PW-1:0]     grant_c;
   logic [PW-1:0]     ptr_inc;
   logic              any_req;
   logic [IW-1:0]     idx;
   logic [CW-1:0]     cnt;
   logic              timeout_hit;
   logic [WIDTH-1:0]  req_q;
   logic [WIDTH-1:0]  rsp_q;
   logic              err_q;

   // First requesting master at or after rr_ptr, wrapping modulo NUM_M.
   always_comb begin
      any_req = 1'b0;
      grant_c = '0;
      idx     = '0;
      for (int i = 0; i < NUM_M; i++) begin
         idx = IW'(rr_ptr) + IW'(i);
         if (idx >= IW'(NUM_M)) begin
            idx = idx - IW'(NUM_M);
         end
         if (!any_req && m_req_valid[idx[PW-1:0]]) begin
            any_req = 1'b1;
            grant_c = idx[PW-1:0];
         end
      end
   end

   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
   assign ptr_inc     = (grant_q == PW'(NUM_M - 1)) ? '0 : grant_q + 1'b1;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = REQ;
         REQ:     if (s_req_ready) state_nxt = WAIT;
         WAIT:    if (s_rsp_valid || timeout_hit) state_nxt = RSP;
         RSP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rr_ptr  <= '0;
         grant_q <= '0;
         cnt     <= '0;
         req_q   <= '0;
         rsp_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_q <= grant_c;
                  req_q   <= m_req_data[grant_c*WIDTH +: WIDTH];
               end
            end
            REQ: begin
               if (s_req_ready) begin
                  cnt <= '0;
               end
            end
            WAIT: begin
               // A response arriving on the timeout cycle still wins.
               if (s_rsp_valid) begin
                  rsp_q <= s_rsp_data;
                  err_q <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (timeout_hit) begin
                     rsp_q <= '0;
                     err_q <= 1'b1;
                  end
               end
            end
            RSP: begin
               rr_ptr <= ptr_inc;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      m_req_ready = '0;
      m_rsp_valid = '0;
      m_rsp_data  = '0;
      m_rsp_err   = 1'b0;
      s_req_valid = 1'b0;
      s_req_data  = '0;
      if (!Reset) begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  m_req_ready[grant_c] = 1'b1;
               end
            end
            REQ: begin
               s_req_valid = 1'b1;
               s_req_data  = req_q;
            end
            RSP: begin
               m_rsp_valid[grant_q] = 1'b1;
               m_rsp_data           = rsp_q;
               m_rsp_err            = err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 2, data width of request and response paths (>=1).
- NUM_M, 4, number of master channels (2..16).
- TIMEOUT, 16, max cycles waited for a slave response (>=1).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- Clk, input, 1, sole clock, rising edge.
- Reset, input, 1, synchronous, active-high reset.
- m_req_valid, input, NUM_M, per-master request pending.
- m_req_data, input, NUM_M*WIDTH, master i data at bits [i*WIDTH +: WIDTH].
- m_req_ready, output, NUM_M, one-hot accept pulse to granted master.
- m_rsp_valid, output, NUM_M, one-hot response pulse to granted master.
- m_rsp_data, output, WIDTH, response data, shared by all masters.
- m_rsp_err, output, 1, response is a timeout error, qualified by m_rsp_valid.
- s_req_valid, output, 1, request presented to slave.
- s_req_data, output, WIDTH, request data to slave.
- s_req_ready, input, 1, slave accepts request.
- s_rsp_valid, input, 1, slave response strobe.
- s_rsp_data, input, WIDTH, slave response data.
REQ-003 Clocking SHALL be one clock (Clk); Reset SHALL be synchronous and active-high.

Function
REQ-004 FSM SHALL have states IDLE, REQ, WAIT, RSP, with exactly one transaction in flight.
REQ-005 In IDLE with any m_req_valid set, grant SHALL go to the first set bit at or after rr_ptr, searching upward with wrap modulo NUM_M.
REQ-006 In that same cycle, m_req_ready[grant] SHALL be 1 for exactly one cycle and all other bits 0; data SHALL latch into the request register; next state SHALL be REQ.
REQ-007 In IDLE with no m_req_valid set, the block SHALL stay in IDLE and all outputs SHALL be 0.
REQ-008 In REQ, s_req_valid SHALL be 1 and s_req_data SHALL equal the latched data (stable); REQ SHALL go to WAIT on the cycle s_req_ready=1 and hold otherwise.
REQ-009 Latency: accept at cycle T SHALL produce s_req_valid=1 at T+1 at the earliest.
REQ-010 s_rsp_valid SHALL be sampled only in WAIT; it SHALL be ignored in IDLE, REQ (including the s_req_ready cycle) and RSP.
REQ-011 In WAIT, the timeout counter SHALL clear on entry and increment each cycle without s_rsp_valid; its width SHALL be $clog2(TIMEOUT+1).
REQ-012 In WAIT, s_rsp_valid=1 SHALL latch s_rsp_data, set err=0, and go to RSP.
REQ-013 In WAIT, reaching counter=TIMEOUT-1 without s_rsp_valid SHALL set data=0, set err=1, and go to RSP.
REQ-014 In WAIT, if s_rsp_valid and timeout coincide, the response SHALL win and err SHALL be 0.
REQ-015 In RSP, m_rsp_valid[grant] SHALL be 1 for exactly one cycle, with m_rsp_data and m_rsp_err driven from the latched values; they SHALL be 0 in all other states.
REQ-016 In RSP, rr_ptr SHALL become (grant+1) mod NUM_M and next state SHALL be IDLE.
REQ-017 Response latency: s_rsp_valid at cycle R SHALL produce m_rsp_valid at R+1.
REQ-018 Back-to-back: a new grant SHALL be possible in the IDLE cycle immediately after RSP.
REQ-019 A master dropping m_req_valid after acceptance SHALL NOT affect the in-flight transaction.

Reset
REQ-020 Reset=1 at a rising edge SHALL force state=IDLE, rr_ptr=0, counter=0, and request/response/err registers to 0.
REQ-021 While Reset=1, all outputs SHALL be 0.
REQ-022 Reset asserted mid-transaction (any state) SHALL abandon the transaction with no m_rsp_valid issued.
REQ-023 The first post-reset grant SHALL search from master 0.

Verification
REQ-024 Bench setup for all scenarios: WIDTH=2, NUM_M=4, TIMEOUT=4.
REQ-025 Single request: m0 valid, data=2'b10, s_req_ready=1 immediately, s_rsp_valid one cycle later with data 2'b01 -> m_req_ready=0001 at T, s_req_data=10 at T+1, m_rsp_valid=0001 with data 01 and err=0.
REQ-026 Round-robin: all four masters held valid -> grant order 0,1,2,3,0 across five transactions.
REQ-027 Wrap: after m3 is served, only m1 and m2 valid -> m1 granted next (pointer wraps 3->0, first set bit is 1).
REQ-028 Timeout: slave never responds -> m_rsp_valid pulses 4 cycles after WAIT entry with data=00 and err=1; pointer advances.
REQ-029 Slave backpressure plus early response: s_req_ready low 3 cycles, s_rsp_valid asserted in the s_req_ready cycle -> s_req_valid held 4 cycles, early response ignored, timeout follows.
REQ-030 Reset mid-WAIT: Reset pulsed -> no m_rsp_valid, all outputs 0, next grant to the lowest valid index starting from 0.
